// File: rtl/projectile_pkg.sv
// projectile_pkg
// Shared types and default constants for the fireball launch controller.
// shot_state_t : per-player shot sequencing state (2-bit)
// CNT_W        : width of the per-channel frame counter
// *_DEF        : default values for the projectile_ctrl parameters
package projectile_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WINDUP   = 2'd1,
    FLYING   = 2'd2,
    COOLDOWN = 2'd3
  } shot_state_t;

  localparam int CNT_W             = 8;
  localparam int X_W               = 10;
  localparam int WINDUP_FRAMES_DEF   = 6;
  localparam int COOLDOWN_FRAMES_DEF = 30;
  localparam int MAX_FLIGHT_DEF      = 160;
  localparam int X_EDGE_DEF          = 630;

endpackage

// File: rtl/shot_fsm.sv
// shot_fsm
// One player's shot sequencer: IDLE -> WINDUP -> FLYING -> COOLDOWN -> IDLE.
// Ports:
//   frame_clk     : one tick per video frame
//   Reset         : asynchronous, active-high
//   startscreen   : menu active, forces IDLE (highest priority)
//   shoot         : level fire key, only a rising edge launches
//   ballcollision : ball overlaps opponent (honoured in FLYING only)
//   BallX         : ball X from the motion block
//   flying/windup/ready : registered state decodes
//   hit           : one-frame pulse when a flight ends by collision
module shot_fsm
  import projectile_pkg::*;
#(
  parameter int WINDUP_FRAMES   = WINDUP_FRAMES_DEF,
  parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF,
  parameter int MAX_FLIGHT      = MAX_FLIGHT_DEF,
  parameter int X_EDGE          = X_EDGE_DEF
) (
  input  logic           frame_clk,
  input  logic           Reset,
  input  logic           startscreen,
  input  logic           shoot,
  input  logic           ballcollision,
  input  logic [X_W-1:0] BallX,
  output logic           flying,
  output logic           windup,
  output logic           hit,
  output logic           ready
);

  localparam logic [CNT_W-1:0] WIND_LD     = CNT_W'(WINDUP_FRAMES - 1);
  localparam logic [CNT_W-1:0] COOL_LD     = CNT_W'(COOLDOWN_FRAMES - 1);
  localparam logic [CNT_W-1:0] FLIGHT_LAST = CNT_W'(MAX_FLIGHT - 1);
  localparam logic [X_W-1:0]   EDGE        = X_W'(X_EDGE);

  shot_state_t      state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             shoot_q;
  logic             nxt_hit;
  logic             off_screen;

  // A ball wrapping left past 0 reads as >= 1019, so one unsigned compare
  // catches both edges. The first two flight frames are skipped because the
  // motion block still reports the previous position.
  assign off_screen = (BallX > EDGE) && (cnt >= CNT_W'(2));

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_hit   = 1'b0;
    if (startscreen) begin
      nxt_state = IDLE;
      nxt_cnt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (shoot && !shoot_q) begin
            nxt_state = WINDUP;
            nxt_cnt   = WIND_LD;
          end
        end
        WINDUP: begin
          if (cnt == '0) begin
            nxt_state = FLYING;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt - 1'b1;
          end
        end
        FLYING: begin
          if (ballcollision || off_screen || (cnt == FLIGHT_LAST)) begin
            nxt_state = COOLDOWN;
            nxt_cnt   = COOL_LD;
            nxt_hit   = ballcollision;  // collision wins over edge/timeout
          end else if (cnt != '1) begin
            nxt_cnt = cnt + 1'b1;
          end
        end
        COOLDOWN: begin
          if (cnt == '0) nxt_state = IDLE;
          else           nxt_cnt   = cnt - 1'b1;
        end
        default: begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      shoot_q <= 1'b0;
      flying  <= 1'b0;
      windup  <= 1'b0;
      hit     <= 1'b0;
      ready   <= 1'b1;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      shoot_q <= shoot;
      flying  <= (nxt_state == FLYING);
      windup  <= (nxt_state == WINDUP);
      hit     <= nxt_hit;
      ready   <= (nxt_state == IDLE);
    end
  end

endmodule

// File: rtl/projectile_ctrl.sv
// projectile_ctrl
// Two independent fireball launch channels (player 1 and player 2).
// Ports:
//   frame_clk, Reset (async, active-high), startscreen
//   shoot/shoot2, ballcollision/ballcollision2, BallX/BallX2 : per-player inputs
//   flying/flying2, windup/windup2, hit/hit2, ready/ready2   : per-player outputs
module projectile_ctrl
  import projectile_pkg::*;
#(
  parameter int WINDUP_FRAMES   = WINDUP_FRAMES_DEF,
  parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF,
  parameter int MAX_FLIGHT      = MAX_FLIGHT_DEF,
  parameter int X_EDGE          = X_EDGE_DEF
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       startscreen,
  input  logic       shoot,
  input  logic       shoot2,
  input  logic       ballcollision,
  input  logic       ballcollision2,
  input  logic [9:0] BallX,
  input  logic [9:0] BallX2,
  output logic       flying,
  output logic       flying2,
  output logic       windup,
  output logic       windup2,
  output logic       hit,
  output logic       hit2,
  output logic       ready,
  output logic       ready2
);

  shot_fsm #(
    .WINDUP_FRAMES(WINDUP_FRAMES), .COOLDOWN_FRAMES(COOLDOWN_FRAMES),
    .MAX_FLIGHT(MAX_FLIGHT), .X_EDGE(X_EDGE)
  ) u_ch1 (
    .frame_clk(frame_clk), .Reset(Reset), .startscreen(startscreen),
    .shoot(shoot), .ballcollision(ballcollision), .BallX(BallX),
    .flying(flying), .windup(windup), .hit(hit), .ready(ready)
  );

  shot_fsm #(
    .WINDUP_FRAMES(WINDUP_FRAMES), .COOLDOWN_FRAMES(COOLDOWN_FRAMES),
    .MAX_FLIGHT(MAX_FLIGHT), .X_EDGE(X_EDGE)
  ) u_ch2 (
    .frame_clk(frame_clk), .Reset(Reset), .startscreen(startscreen),
    .shoot(shoot2), .ballcollision(ballcollision2), .BallX(BallX2),
    .flying(flying2), .windup(windup2), .hit(hit2), .ready(ready2)
  );

endmodule

// File: tb/tb_projectile_ctrl.sv
module tb_projectile_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset, startscreen;
  logic       shoot, shoot2, ballcollision, ballcollision2;
  logic [9:0] BallX, BallX2;
  logic       flying, flying2, windup, windup2, hit, hit2, ready, ready2;

  int total = 0;
  int bad   = 0;

  // Per-channel expected nibble: {hit, ready, windup, flying}
  localparam logic [3:0] I_ = 4'b0100;
  localparam logic [3:0] W_ = 4'b0010;
  localparam logic [3:0] F_ = 4'b0001;
  localparam logic [3:0] C_ = 4'b0000;
  localparam logic [3:0] H_ = 4'b1000;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];

  projectile_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .startscreen(startscreen),
    .shoot(shoot), .shoot2(shoot2),
    .ballcollision(ballcollision), .ballcollision2(ballcollision2),
    .BallX(BallX), .BallX2(BallX2),
    .flying(flying), .flying2(flying2), .windup(windup), .windup2(windup2),
    .hit(hit), .hit2(hit2), .ready(ready), .ready2(ready2)
  );

  always #5 frame_clk = ~frame_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  task automatic expect_out(input string tag, input logic [3:0] e1, input logic [3:0] e2);
    exp_t e;
    e.tag = tag;
    e.exp = {e2, e1};
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t       e;
    logic [7:0] act;
    e   = sb.pop_front();
    act = {hit2, ready2, windup2, flying2, hit, ready, windup, flying};
    total++;
    assert (act === e.exp) else begin
      bad++;
      $error("FAIL %s got=%b want=%b", e.tag, act, e.exp);
    end
  endtask

  // Queue expectation for n frames, each checked 1 time unit after the edge.
  task automatic step(input string tag, input logic [3:0] e1, input logic [3:0] e2,
                      input int n = 1);
    for (int i = 0; i < n; i++) begin
      expect_out(tag, e1, e2);
      @(posedge frame_clk);
      #1;
      check_now();
    end
  endtask

  initial begin
    Reset = 1'b1; startscreen = 1'b0;
    shoot = 1'b0; shoot2 = 1'b0;
    ballcollision = 1'b0; ballcollision2 = 1'b0;
    BallX = 10'd300; BallX2 = 10'd300;

    // Reset state
    #2;
    expect_out("reset_async", I_, I_);
    check_now();
    step("reset_held", I_, I_, 2);
    Reset = 1'b0;
    step("idle", I_, I_, 2);

    // Press for 3 frames: 6 windup frames, then flying, no second shot
    shoot = 1'b1;
    step("windup_a", W_, I_, 3);
    shoot = 1'b0;
    step("windup_b", W_, I_, 3);
    step("launch", F_, I_);

    // BallX +5 from 600: 630 is not past the edge, 635 is
    for (int k = 0; k < 7; k++) begin
      BallX = 10'(600 + 5 * k);
      step("fly_step", F_, I_);
    end
    BallX = 10'd635;
    step("edge_exit", C_, I_);
    BallX = 10'd300;
    step("cooldown", C_, I_, 29);
    step("ready_back", I_, I_);

    // Held key + collision with off-screen X on same frame -> hit
    shoot = 1'b1;
    step("w2", W_, I_, 6);
    step("f2", F_, I_);
    ballcollision = 1'b1; BallX = 10'd640;
    step("hit_pulse", H_, I_);
    step("hit_clear", C_, I_);          // collision ignored in cooldown
    ballcollision = 1'b0; BallX = 10'd300;
    step("cool2", C_, I_, 28);
    step("ready2_back", I_, I_);
    step("held_no_refire", I_, I_, 3);
    shoot = 1'b0;
    step("released", I_, I_);

    // Wrapped X on flight frame 1 ignored, on frame 3 ends flight
    shoot = 1'b1;
    step("w3", W_, I_);
    shoot = 1'b0;
    step("w3b", W_, I_, 5);
    step("f3", F_, I_);
    BallX = 10'd1020;
    step("wrap_ignored", F_, I_);
    BallX = 10'd300;
    step("wrap_gap", F_, I_);
    BallX = 10'd1020;
    step("wrap_exit", C_, I_);
    BallX = 10'd300;
    step("cool3", C_, I_, 29);
    step("ready3", I_, I_);

    // Timeout: exactly 160 flying frames
    shoot = 1'b1;
    step("w4", W_, I_);
    shoot = 1'b0;
    step("w4b", W_, I_, 5);
    step("f4", F_, I_, 160);
    step("timeout_exit", C_, I_);
    step("cool4", C_, I_, 29);
    step("ready4", I_, I_);

    // startscreen overrides FLYING (with collision) and WINDUP
    shoot = 1'b1;
    step("w5", W_, I_);
    shoot = 1'b0;
    step("w5b", W_, I_, 5);
    step("f5", F_, I_);
    shoot2 = 1'b1;
    step("ch2_windup", F_, W_);
    shoot2 = 1'b0;
    step("ch2_windup_b", F_, W_);
    startscreen = 1'b1; ballcollision = 1'b1; ballcollision2 = 1'b1;
    step("menu_abort", I_, I_);
    startscreen = 1'b0; ballcollision = 1'b0; ballcollision2 = 1'b0;
    step("menu_idle", I_, I_);

    // Simultaneous shots, then async reset mid-flight
    shoot = 1'b1; shoot2 = 1'b1;
    step("dual_w", W_, W_);
    shoot = 1'b0; shoot2 = 1'b0;
    step("dual_wb", W_, W_, 5);
    step("dual_fly", F_, F_, 3);
    #3;
    Reset = 1'b1;
    #1;
    expect_out("async_reset", I_, I_);
    check_now();
    #2;
    Reset = 1'b0;
    step("post_reset", I_, I_);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
